// File: rtl/inst_buffer_pkg.sv
// Shared types and width helpers for the inst_buffer instruction queue.
// Optional bypass feature in inst_buffer is enabled by INST_BUFFER_BYPASS_EN.
package inst_buffer_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ib_entry_t;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_buffer_mem.sv
// DEPTH-entry register array: FETCH_WIDTH write ports at consecutive indices
// from i_wbase and ISSUE_WIDTH read ports from i_rbase, all modulo DEPTH.
module inst_buffer_mem
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic      [FETCH_WIDTH-1:0]          i_we,
  input  logic      [$clog2(DEPTH)-1:0]        i_wbase,
  input  ib_entry_t [FETCH_WIDTH-1:0]          i_wdata,
  input  logic      [$clog2(DEPTH)-1:0]        i_rbase,
  output ib_entry_t [ISSUE_WIDTH-1:0]          o_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  ib_entry_t r_mem [DEPTH];

  // Power-of-two depth: index arithmetic wraps naturally at AW bits.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      if (i_we[k]) r_mem[AW'(i_wbase + AW'(k))] <= i_wdata[k];
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      o_rdata[k] = r_mem[AW'(i_rbase + AW'(k))];
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Multi-slot circular instruction queue between fetch and decode.
// Define INST_BUFFER_BYPASS_EN for a same-cycle fetch->issue path on empty.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              stall,
  input  logic [FETCH_WIDTH-1:0]            fetch_valid_i,
  input  logic [FETCH_WIDTH*32-1:0]         fetch_pc_i,
  input  logic [FETCH_WIDTH*32-1:0]         fetch_inst_i,
  output logic                              fetch_ready_o,
  output logic [ISSUE_WIDTH-1:0]            issue_valid_o,
  output logic [ISSUE_WIDTH*32-1:0]         issue_pc_o,
  output logic [ISSUE_WIDTH*32-1:0]         issue_inst_o,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]  issue_accept_i,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = ptr_width(DEPTH);
  localparam int unsigned CW  = cnt_width(DEPTH);
  localparam int unsigned FCW = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned ICW = $clog2(ISSUE_WIDTH + 1);

  logic      [PW-1:0]          r_head;
  logic      [PW-1:0]          r_tail;
  logic      [PW-1:0]          w_count;
  logic      [FCW-1:0]         w_pref;
  logic                        w_run;
  logic      [FCW-1:0]         w_nin;
  logic      [ICW-1:0]         w_nout;
  logic      [PW-1:0]          w_head_inc;
  logic      [PW-1:0]          w_tail_inc;
  logic      [FETCH_WIDTH-1:0] w_we;
  ib_entry_t [FETCH_WIDTH-1:0] w_wdata;
  ib_entry_t [ISSUE_WIDTH-1:0] w_rd;
`ifdef INST_BUFFER_BYPASS_EN
  logic                        w_byp;
`endif

  assign w_count       = r_tail - r_head;
  assign count_o       = CW'(w_count);
  assign fetch_ready_o = rst && (32'(w_count) + FETCH_WIDTH <= DEPTH);

  always_comb begin
    w_pref = '0;
    w_run  = 1'b1;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      w_run = w_run & fetch_valid_i[k];
      if (w_run) w_pref = w_pref + FCW'(1);
    end
  end

  assign w_nin  = fetch_ready_o ? w_pref : '0;
  assign w_nout = stall ? '0 : issue_accept_i;

`ifdef INST_BUFFER_BYPASS_EN
  assign w_byp = (w_count == '0) && !flush;
`endif

  always_comb begin
    w_we       = '0;
    w_wdata    = '0;
    w_head_inc = PW'(w_nout);
    w_tail_inc = PW'(w_nin);
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      w_we[k]         = (FCW'(k) < w_nin) && !flush;
      w_wdata[k].pc   = fetch_pc_i[32*k +: 32];
      w_wdata[k].inst = fetch_inst_i[32*k +: 32];
    end
`ifdef INST_BUFFER_BYPASS_EN
    // Bypassed slots are consumed directly; only the unaccepted tail of the
    // fetch group is shifted down onto write port 0.. and stored.
    if (w_byp) begin
      w_head_inc = '0;
      w_tail_inc = PW'(w_nin) - PW'(w_nout);
      for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
        w_we[k] = 1'b0;
        if (k + 32'(w_nout) < 32'(w_nin)) begin
          w_we[k]         = 1'b1;
          w_wdata[k].pc   = fetch_pc_i[32*(k + 32'(w_nout)) +: 32];
          w_wdata[k].inst = fetch_inst_i[32*(k + 32'(w_nout)) +: 32];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + w_head_inc;
      r_tail <= r_tail + w_tail_inc;
    end
  end

  inst_buffer_mem #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FETCH_WIDTH),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_wbase (r_tail[AW-1:0]),
    .i_wdata (w_wdata),
    .i_rbase (r_head[AW-1:0]),
    .o_rdata (w_rd)
  );

  always_comb begin
    issue_valid_o = '0;
    issue_pc_o    = '0;
    issue_inst_o  = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      issue_valid_o[k]        = 32'(w_count) > k;
      issue_pc_o[32*k +: 32]   = w_rd[k].pc;
      issue_inst_o[32*k +: 32] = w_rd[k].inst;
    end
`ifdef INST_BUFFER_BYPASS_EN
    if (w_byp) begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        issue_valid_o[k] = 1'b0;
        if (k < FETCH_WIDTH) begin
          issue_valid_o[k]        = k < 32'(w_nin);
          issue_pc_o[32*k +: 32]   = fetch_pc_i[32*k +: 32];
          issue_inst_o[32*k +: 32] = fetch_inst_i[32*k +: 32];
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_inst_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned FW    = 2;
  localparam int unsigned IW    = 2;

  logic            clk = 1'b0;
  logic            rst, flush, stall;
  logic [FW-1:0]   fv;
  logic [FW*32-1:0] fpc, finst;
  logic            fready;
  logic [IW-1:0]   ivalid;
  logic [IW*32-1:0] ipc, iinst;
  logic [1:0]      acc;
  logic [3:0]      cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] q[$];
  bit          known = 1'b0;

  always #5 clk = ~clk;

  inst_buffer #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FW),
    .ISSUE_WIDTH (IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stall          (stall),
    .fetch_valid_i  (fv),
    .fetch_pc_i     (fpc),
    .fetch_inst_i   (finst),
    .fetch_ready_o  (fready),
    .issue_valid_o  (ivalid),
    .issue_pc_o     (ipc),
    .issue_inst_o   (iinst),
    .issue_accept_i (acc),
    .count_o        (cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prefix_len(input logic [FW-1:0] v);
    int n = 0;
    for (int k = 0; k < int'(FW); k++) begin
      if (v[k] !== 1'b1) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit model_ready(input logic r);
    return (r === 1'b1) && (int'(DEPTH) - q.size() >= int'(FW));
  endfunction

  function automatic bit bypass_now();
`ifdef INST_BUFFER_BYPASS_EN
    return known && q.size() == 0 && flush !== 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_vcount();
    int n;
    if (bypass_now()) n = model_ready(rst) ? prefix_len(fv) : 0;
    else              n = q.size();
    return (n < int'(IW)) ? n : int'(IW);
  endfunction

  // Reference model: a queue of {pc, inst}; enqueue appends, dequeue pops front.
  always @(posedge clk) begin
    int n_in, n_out;
    if (rst === 1'b0) begin
      q.delete();
      known = 1'b1;
    end else if (known) begin
      if (flush === 1'b1) q.delete();
      else begin
        n_in  = model_ready(1'b1) ? prefix_len(fv) : 0;
        n_out = (stall === 1'b1) ? 0 : int'(acc);
        if (n_out > exp_vcount()) begin
          errors++;
          $display("FAIL illegal_accept: got %0d expected <= %0d", n_out, exp_vcount());
        end
        for (int k = 0; k < n_in; k++) q.push_back({fpc[32*k +: 32], finst[32*k +: 32]});
        for (int k = 0; k < n_out; k++) if (q.size() > 0) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    int vc;
    if (known) begin
      vc = exp_vcount();
      check("count", 64'(cnt), 64'(q.size()));
      check("ready", 64'(fready), 64'(model_ready(rst)));
      check("valid", 64'(ivalid), 64'((1 << vc) - 1));
      for (int k = 0; k < vc; k++) begin
        if (bypass_now()) begin
          check("byp_pc",   64'(ipc[32*k +: 32]),   64'(fpc[32*k +: 32]));
          check("byp_inst", 64'(iinst[32*k +: 32]), 64'(finst[32*k +: 32]));
        end else begin
          check("pc",   64'(ipc[32*k +: 32]),   64'(q[k][63:32]));
          check("inst", 64'(iinst[32*k +: 32]), 64'(q[k][31:0]));
        end
      end
    end
  end

  task automatic set_in(input logic r, input logic f, input logic s, input logic [1:0] v,
                        input logic [31:0] pc0, input logic [31:0] pc1, input logic [1:0] a);
    rst   = r;
    flush = f;
    stall = s;
    fv    = v;
    fpc   = {pc1, pc0};
    finst = {pc1 ^ 32'hA5A5_0000, pc0 ^ 32'h5A5A_0000};
    acc   = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vc;
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();
    step();
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    #1;
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_valid", 64'(ivalid), 64'd0);
    check("rst_ready", 64'(fready), 64'd1);

    // Fill: 2,4,6,8 then hold at 8
    set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h1c000000, 32'h1c000004, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("fill_count", 64'(cnt), 64'((i < 4 ? i : 4) * 2));
    end
    check("fill_ready", 64'(fready), 64'd0);
    check("fill_pc0", 64'(ipc[31:0]), 64'h1c000000);

    // Steady stream
    set_in(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();
    check("flush_count", 64'(cnt), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h2000, 32'h2004, 2'd0);
    step();
    check("stream_start", 64'(cnt), 64'd2);
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h2008 + 32'(8*i), 32'h200c + 32'(8*i), 2'd2);
      step();
      check("stream_count", 64'(cnt), 64'd2);
      check("stream_pc0", 64'(ipc[31:0]), 64'(32'h2008 + 32'(8*i)));
    end

    // Partial prefix
    set_in(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();
    set_in(1'b1, 1'b0, 1'b0, 2'b10, 32'h3000, 32'h3004, 2'd0);
    step();
    check("prefix_10", 64'(cnt), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 2'b01, 32'h3000, 32'h3004, 2'd0);
    step();
    check("prefix_01", 64'(cnt), 64'd1);

    // Flush with traffic
    set_in(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h4000 + 32'(8*i), 32'h4004 + 32'(8*i), 2'd0);
      step();
    end
    check("pre_flush", 64'(cnt), 64'd6);
    set_in(1'b1, 1'b1, 1'b0, 2'b11, 32'hdead0000, 32'hdead0004, 2'd2);
    step();
    check("flush_traffic_count", 64'(cnt), 64'd0);
    check("flush_traffic_valid", 64'(ivalid), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();

    // Stall
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h5000 + 32'(8*i), 32'h5004 + 32'(8*i), 2'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'd2);
      step();
      check("stall_count", 64'(cnt), 64'd4);
      check("stall_pc0", 64'(ipc[31:0]), 64'h5000);
    end

    // Empty-buffer fetch: bypass vs. registered path
    set_in(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();
`ifdef INST_BUFFER_BYPASS_EN
    set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h100, 32'h104, 2'd1);
    #1;
    check("byp_same_valid", 64'(ivalid), 64'd3);
    check("byp_same_pc0", 64'(ipc[31:0]), 64'h100);
    step();
    check("byp_next_count", 64'(cnt), 64'd1);
    check("byp_next_pc0", 64'(ipc[31:0]), 64'h104);
`else
    set_in(1'b1, 1'b0, 1'b0, 2'b11, 32'h100, 32'h104, 2'd0);
    #1;
    check("nobyp_same_valid", 64'(ivalid), 64'd0);
    step();
    check("nobyp_next_count", 64'(cnt), 64'd2);
    check("nobyp_next_pc0", 64'(ipc[31:0]), 64'h100);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 199) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
             2'($urandom), $urandom, $urandom, 2'd0);
      vc = (rst === 1'b1) ? exp_vcount() : 0;
      acc = 2'($urandom_range(0, vc));
      step();
    end

    set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Parametrised multi-slot instruction queue between the fetch stage and decode, replacing the single-entry fetch buffer and IF/ID register pair. It accepts up to FETCH_WIDTH {pc, inst} pairs per cycle, stores them in a circular buffer of DEPTH entries, and presents up to ISSUE_WIDTH oldest entries to decode in program order. Decode consumes a variable count per cycle. The queue clears on pipeline flush and on branch redirect.

## Interface
- DEPTH, 8, entry count; power of two, ≥ 2*max(FETCH_WIDTH, ISSUE_WIDTH)
- FETCH_WIDTH, 2, enqueue slots per cycle
- ISSUE_WIDTH, 2, dequeue slots per cycle
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- flush  in  1  clear all entries (exception/branch redirect)
- stall  in  1  decode stalled; forces dequeue count to 0
- fetch_valid_i  in  FETCH_WIDTH  per-slot valid; only the contiguous prefix from slot 0 counts
- fetch_pc_i  in  FETCH_WIDTH*32  slot k at bits [32k+31:32k]
- fetch_inst_i  in  FETCH_WIDTH*32  same packing
- fetch_ready_o  out  1  free entries ≥ FETCH_WIDTH
- issue_valid_o  out  ISSUE_WIDTH  prefix-valid; slot 0 = oldest
- issue_pc_o  out  ISSUE_WIDTH*32  slot packing as fetch
- issue_inst_o  out  ISSUE_WIDTH*32  slot packing as fetch
- issue_accept_i  in  $clog2(ISSUE_WIDTH+1)  entries decode consumes this cycle
- count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH × {pc[31:0], inst[31:0]}; head/tail pointers of $clog2(DEPTH)+1 bits (MSB is wrap bit); count = tail − head.
- Enqueue count n_in = fetch_ready_o ? length of the 1-prefix of fetch_valid_i : 0. Slot k writes entry tail+k (mod DEPTH). Slots after the first 0 are ignored.
- Dequeue count n_out = stall ? 0 : issue_accept_i. issue_accept_i > popcount(issue_valid_o) is illegal; the bench asserts on it, and RTL behaviour is undefined.
- Issue outputs: slot k shows entry head+k; issue_valid_o[k] = (count > k). Data on invalid slots is don't-care.
- fetch_ready_o = rst && (DEPTH − count ≥ FETCH_WIDTH), using registered count only, with no same-cycle dequeue credit.
- Next state: head += n_out; tail += n_in; count updated together. Simultaneous enqueue and dequeue are legal at any occupancy.
- flush (rst high): head = tail = 0, count = 0; that cycle's enqueue and dequeue are discarded. flush has priority over everything except rst.
- Reset (rst low at posedge): head = tail = 0. Storage is not cleared. Outputs after reset: issue_valid_o = 0, count_o = 0, fetch_ready_o = 1 (fetch_ready_o is 0 while rst is low).
- Wrap-around: the pointer MSB distinguishes full (count = DEPTH) from empty. Multi-slot writes and reads spanning index DEPTH−1→0 are contiguous modulo DEPTH.

## Timing
- Enqueue-to-issue latency is 1 cycle. A pair written at edge N appears on issue_* after edge N.
- issue_* and fetch_ready_o are combinational from registers only, with no input-to-output path, except under the bypass option below.
- Dequeue takes effect at the edge where issue_accept_i is sampled; the next entries appear in the following cycle.
- flush asserted in cycle N gives issue_valid_o = 0 and count_o = 0 from cycle N+1.

## Configuration
- INST_BUFFER_BYPASS_EN defined: when count = 0 and flush = 0, fetch slots drive issue_* combinationally in the same cycle, with issue_valid_o = the fetch prefix truncated to ISSUE_WIDTH. Accepted slots are not written; remaining slots are enqueued at tail. This saves 1 cycle on an empty buffer.
- Undefined: no combinational fetch→issue path, and latency is always 1 cycle.

## Structure
- Shared package holds the instruction/address width constant (32), the ib_entry_t struct {pc, inst}, and the pointer/count width helper functions.
- One sub-module: inst_buffer_mem, a DEPTH-entry register array with FETCH_WIDTH write ports and ISSUE_WIDTH read ports (pointer-indexed, modulo DEPTH). Pointer, count and bypass logic stay in inst_buffer.

## Test plan
- Reset then fill: rst low 2 cycles, then fetch_valid_i = 2'b11 with pcs 0x1c000000/0x1c000004 every cycle and issue_accept_i = 0 → count_o 2,4,6,8; fetch_ready_o drops to 0 when count_o = 7 or 8 (free < 2); issue slot0 pc = 0x1c000000.
- Steady stream: enqueue 2, accept 2 per cycle for 20 cycles → count_o stays 2, issue pcs increase by 8 per cycle, head/tail wrap twice, no loss or reorder.
- Partial prefix: fetch_valid_i = 2'b10 → nothing enqueued. 2'b01 → count +1.
- Flush with traffic: count 6, flush = 1 together with enqueue 2 and accept 2 → next cycle count_o = 0 and issue_valid_o = 0; the flushed-cycle pcs never appear.
- Stall: count 4, stall = 1, issue_accept_i = 2 for 3 cycles → count_o stays 4 and issue_pc_o is unchanged.
- Bypass (INST_BUFFER_BYPASS_EN): empty buffer, fetch 2 with pc 0x100, accept 1 → same cycle issue_pc slot0 = 0x100; next cycle count_o = 1 and slot0 = 0x104. Without the macro, issue_valid_o = 0 in the same cycle.
